// File: rtl/ltc2308_responder.sv
// Target-side LTC2308 model: answers CONVST/SCK/SDI from the FPGA master with
// 12-bit samples taken from a parallel input, all pins oversampled on clk.
module ltc2308_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CYCLES = 80,
  parameter int NBITS       = 12,
  parameter int CFG_BITS    = 6
) (
  input  logic             FPGA_CLK1_50,
  input  logic             reset_n,
  input  logic             ADC_CONVST,
  input  logic             ADC_SCK,
  input  logic             ADC_SDI,
  output logic             ADC_SDO,
  input  logic [NBITS-1:0] sample_in,
  output logic [2:0]       sample_ch,
  output logic             sample_diff,
  output logic             sample_take,
  output logic             cfg_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int BIT_W = $clog2(NBITS + 1);

  localparam logic [CNT_W-1:0]    CNT_LOAD     = CNT_W'(CONV_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE      = CNT_W'(1);
  localparam logic [BIT_W-1:0]    BIT_ONE      = BIT_W'(1);
  localparam logic [BIT_W-1:0]    BIT_CFG      = BIT_W'(CFG_BITS);
  localparam logic [BIT_W-1:0]    BIT_CFG_LAST = BIT_W'(CFG_BITS - 1);
  localparam logic [BIT_W-1:0]    BIT_MAX      = BIT_W'(NBITS);
  localparam logic [CFG_BITS-1:0] CFG_RESET    = CFG_BITS'(6'b100010);

  typedef enum logic [1:0] {IDLE, CONVERT, READ} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] convst_sync, sck_sync, sdi_sync;
  logic                   convst_prev, sck_prev;
  logic                   convst_s, sck_s, sdi_s;
  logic                   conv_rise, sck_rise, sck_fall;

  logic [NBITS-1:0]    data_reg, conv_word;
  logic [CFG_BITS-1:0] cfg_reg;
  logic [CFG_BITS-2:0] cfg_shift;
  logic [CNT_W-1:0]    conv_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                slp_unused;

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      convst_sync <= '0;
      sck_sync    <= '0;
      sdi_sync    <= '0;
      convst_prev <= 1'b0;
      sck_prev    <= 1'b0;
    end else begin
      convst_sync <= {convst_sync[SYNC_STAGES-2:0], ADC_CONVST};
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], ADC_SCK};
      sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], ADC_SDI};
      convst_prev <= convst_sync[SYNC_STAGES-1];
      sck_prev    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign convst_s   = convst_sync[SYNC_STAGES-1];
  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync[SYNC_STAGES-1];
  assign conv_rise  = convst_s & ~convst_prev;
  assign sck_rise   = sck_s & ~sck_prev;
  assign sck_fall   = ~sck_s & sck_prev;
  assign slp_unused = cfg_reg[0];

  // UNI=0 selects bipolar output: flip the offset-binary MSB.
  assign conv_word = cfg_reg[CFG_BITS-5] ? sample_in
                                         : {~sample_in[NBITS-1], sample_in[NBITS-2:0]};

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (conv_rise) state_d = CONVERT;
      CONVERT: if (conv_cnt <= CNT_ONE) state_d = READ;
      READ:    if (conv_rise) state_d = CONVERT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == CONVERT);
    ADC_SDO = (state == READ) && !convst_s && data_reg[NBITS-1];
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      data_reg    <= '0;
      cfg_reg     <= CFG_RESET;
      cfg_shift   <= '0;
      conv_cnt    <= '0;
      bit_cnt     <= '0;
      sample_take <= 1'b0;
      cfg_valid   <= 1'b0;
      frame_err   <= 1'b0;
      sample_ch   <= '0;
      sample_diff <= 1'b0;
    end else begin
      sample_take <= 1'b0;
      cfg_valid   <= 1'b0;
      frame_err   <= 1'b0;
      sample_ch   <= {cfg_reg[CFG_BITS-3], cfg_reg[CFG_BITS-4], cfg_reg[CFG_BITS-2]};
      sample_diff <= ~cfg_reg[CFG_BITS-1];
      unique case (state)
        IDLE: begin
          if (conv_rise) begin
            data_reg    <= conv_word;
            sample_take <= 1'b1;
            conv_cnt    <= CNT_LOAD;
          end
        end
        CONVERT: begin
          if (conv_cnt != '0) conv_cnt <= conv_cnt - CNT_ONE;
          if (conv_cnt <= CNT_ONE) bit_cnt <= '0;
          if (conv_rise || sck_rise || sck_fall) frame_err <= 1'b1;
        end
        READ: begin
          // CONVST rise wins over a coincident SCK edge, which is dropped silently.
          if (conv_rise) begin
            data_reg    <= conv_word;
            sample_take <= 1'b1;
            conv_cnt    <= CNT_LOAD;
            if (bit_cnt < BIT_CFG) frame_err <= 1'b1;
          end else if ((sck_rise || sck_fall) && convst_s) begin
            frame_err <= 1'b1;
          end else if (sck_rise) begin
            if (bit_cnt < BIT_CFG) cfg_shift <= {cfg_shift[CFG_BITS-3:0], sdi_s};
            if (bit_cnt == BIT_CFG_LAST) begin
              cfg_reg   <= {cfg_shift, sdi_s};
              cfg_valid <= 1'b1;
            end
            if (bit_cnt < BIT_MAX) bit_cnt <= bit_cnt + BIT_ONE;
          end else if (sck_fall) begin
            data_reg <= {data_reg[NBITS-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ltc2308_responder.sv
// Directed bench for ltc2308_responder: table of full frames plus hand-written
// sequences for SCK-during-convert, short frames and mid-frame reset.
module tb_ltc2308_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        convst = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sdo;
  logic [2:0]  sample_ch;
  logic        sample_diff, sample_take, cfg_valid, frame_err, busy;

  int total = 0;
  int bad   = 0;
  int n_take = 0, n_cfg = 0, n_err = 0, n_busy = 0;

  typedef struct {
    logic [11:0] sin;
    logic [5:0]  cfg;
    logic [11:0] sdo;
    logic [2:0]  ch;
    logic        diff;
  } vec_t;

  vec_t vecs[7];

  ltc2308_responder #(
    .SYNC_STAGES(2),
    .CONV_CYCLES(80),
    .NBITS(12),
    .CFG_BITS(6)
  ) dut (
    .FPGA_CLK1_50(clk),
    .reset_n(rst_n),
    .ADC_CONVST(convst),
    .ADC_SCK(sck),
    .ADC_SDI(sdi),
    .ADC_SDO(sdo),
    .sample_in(sample_in),
    .sample_ch(sample_ch),
    .sample_diff(sample_diff),
    .sample_take(sample_take),
    .cfg_valid(cfg_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (sample_take) n_take++;
    if (cfg_valid)   n_cfg++;
    if (frame_err)   n_err++;
    if (busy)        n_busy++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic start_conv(input logic [11:0] sin);
    sample_in = sin;
    @(posedge clk); #1 convst = 1'b1;
    repeat (4) @(posedge clk);
    #1 convst = 1'b0;
  endtask

  task automatic wait_conv();
    int i;
    i = 0;
    while (busy && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    chk("conv_done", busy, 0);
  endtask

  task automatic sck_bits(input logic [5:0] cfg, input int n, output logic [11:0] word);
    word = '0;
    for (int i = 0; i < n; i++) begin
      sdi = (i < 6) ? cfg[5-i] : 1'b0;
      repeat (6) @(posedge clk);
      #1 word = {word[10:0], sdo};
      sck = 1'b1;
      repeat (6) @(posedge clk);
      #1 sck = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [11:0] sin, input logic [5:0] cfg, output logic [11:0] word);
    start_conv(sin);
    wait_conv();
    sck_bits(cfg, 12, word);
  endtask

  initial begin
    int t0, c0, e0, b0;
    logic [11:0] w;

    //          sin       cfg         sdo      ch    diff
    vecs[0] = '{12'hABC, 6'b100010, 12'hABC, 3'd0, 1'b0};
    vecs[1] = '{12'h555, 6'b110010, 12'h555, 3'd1, 1'b0};
    vecs[2] = '{12'h123, 6'b100000, 12'h123, 3'd0, 1'b0};
    vecs[3] = '{12'h800, 6'b001100, 12'h000, 3'd6, 1'b1};
    vecs[4] = '{12'h7FF, 6'b010110, 12'hFFF, 3'd3, 1'b1};
    vecs[5] = '{12'h7FF, 6'b100011, 12'h7FF, 3'd0, 1'b0};
    vecs[6] = '{12'hA5A, 6'b111110, 12'hA5A, 3'd7, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sdo", sdo, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch", sample_ch, 0);
    chk("rst_diff", sample_diff, 0);
    chk("rst_take", sample_take, 0);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_sdo_after", sdo, 0);

    for (int r = 0; r < 7; r++) begin
      t0 = n_take; c0 = n_cfg; e0 = n_err; b0 = n_busy;
      frame(vecs[r].sin, vecs[r].cfg, w);
      chk($sformatf("row%0d_sdo", r), w, vecs[r].sdo);
      chk($sformatf("row%0d_ch", r), sample_ch, vecs[r].ch);
      chk($sformatf("row%0d_diff", r), sample_diff, vecs[r].diff);
      chk($sformatf("row%0d_take", r), n_take - t0, 1);
      chk($sformatf("row%0d_cfg_valid", r), n_cfg - c0, 1);
      chk($sformatf("row%0d_frame_err", r), n_err - e0, 0);
      chk($sformatf("row%0d_busy_cycles", r), n_busy - b0, 80);
    end

    // SCK edges while converting: fall, rise, fall
    t0 = n_take; c0 = n_cfg; e0 = n_err; b0 = n_busy;
    @(posedge clk); #1 sck = 1'b1;
    repeat (8) @(posedge clk);
    start_conv(12'h5A5);
    repeat (6) @(posedge clk); #1 sck = 1'b0;
    repeat (8) @(posedge clk); #1 sck = 1'b1;
    repeat (8) @(posedge clk); #1 sck = 1'b0;
    wait_conv();
    chk("conv_sck_err", n_err - e0, 3);
    chk("conv_sck_busy", n_busy - b0, 80);
    chk("conv_sck_take", n_take - t0, 1);
    chk("conv_sck_cfg", n_cfg - c0, 0);
    e0 = n_err;
    sck_bits(6'b100010, 12, w);
    chk("conv_sck_sdo", w, 12'h5A5);
    chk("conv_sck_frame_err", n_err - e0, 0);
    chk("conv_sck_ch", sample_ch, 0);

    // Short frame: only 4 SCK rises before the next CONVST
    t0 = n_take; c0 = n_cfg; e0 = n_err;
    start_conv(12'h111);
    wait_conv();
    sck_bits(6'b110010, 4, w);
    chk("short_bits", w[3:0], 4'b0001);
    start_conv(12'h3C3);
    chk("short_busy", busy, 1);
    chk("short_err", n_err - e0, 1);
    chk("short_take", n_take - t0, 2);
    chk("short_cfg", n_cfg - c0, 0);
    chk("short_ch", sample_ch, 0);
    wait_conv();
    sck_bits(6'b100010, 12, w);
    chk("short_next_sdo", w, 12'h3C3);
    chk("short_next_err", n_err - e0, 1);

    // Reset in the middle of a read frame
    frame(12'h0F0, 6'b110010, w);
    chk("prereset_sdo_word", w, 12'h0F0);
    chk("prereset_ch", sample_ch, 1);
    start_conv(12'hFFF);
    wait_conv();
    sck_bits(6'b000000, 5, w);
    chk("prereset_bits", w[4:0], 5'b11111);
    chk("prereset_sdo", sdo, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_sdo", sdo, 0);
    chk("midreset_ch", sample_ch, 0);
    chk("midreset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    t0 = n_take; c0 = n_cfg; e0 = n_err; b0 = n_busy;
    frame(12'h9A6, 6'b100010, w);
    chk("postreset_sdo", w, 12'h9A6);
    chk("postreset_ch", sample_ch, 0);
    chk("postreset_err", n_err - e0, 0);
    chk("postreset_cfg", n_cfg - c0, 1);
    chk("postreset_busy", n_busy - b0, 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ltc2308_responder.md
Name: ltc2308_responder

Overview:
- Synthesizable target-side model of the LTC2308 SPI-style ADC interface (CONVST/SCK/SDI/SDO).
- Answers the FPGA-side ADC master exactly as the real converter does.
- Returns 12-bit samples supplied on a parallel input, so a known test tone can drive the FFT/servo path on hardware or in simulation without the physical ADC.
- Oversamples all interface pins in the system clock domain.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on CONVST, SCK and SDI.
- CONV_CYCLES, 80: conversion busy time in clk cycles (1.6 us at 50 MHz).
- NBITS, 12: data word length shifted out.
- CFG_BITS, 6: configuration word length shifted in.

Ports:
- FPGA_CLK1_50  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- ADC_CONVST  input  1  conversion start from master (async).
- ADC_SCK  input  1  serial clock from master (async).
- ADC_SDI  input  1  config data from master (async).
- ADC_SDO  output  1  serial data to master.
- sample_in  input  12  unsigned offset-binary sample for the currently selected channel.
- sample_ch  output  3  channel selected by the last committed config.
- sample_diff  output  1  1 = differential mode committed.
- sample_take  output  1  one-cycle pulse when sample_in is latched.
- cfg_valid  output  1  one-cycle pulse when a new config word is committed.
- frame_err  output  1  one-cycle pulse on a protocol violation.
- busy  output  1  high during CONVERT.

Behaviour:
- Clock and reset: one clock, FPGA_CLK1_50. Reset is asynchronous and active-low on reset_n.
- Reset values: ADC_SDO=0, sample_take=0, cfg_valid=0, frame_err=0, busy=0. Committed config = 6'b100010 (S/D=1, O/S=0, S1=0, S0=0, UNI=1, SLP=0), so sample_ch=0 and sample_diff=0. State IDLE, all counters 0.
- Input sync and edge detect: each async input passes through SYNC_STAGES flops. One further register gives rise/fall detect.
- Master timing requirement: SCK high and low times must each be at least SYNC_STAGES+2 clk periods. SDO updates no later than SYNC_STAGES+2 clk cycles after the physical SCK falling edge.
- State IDLE:
  - CONVST rise: latch data_reg from sample_in, pulse sample_take, load conv counter with CONV_CYCLES, go to CONVERT.
  - Data conversion: if committed UNI=0, data_reg = {~sample_in[11], sample_in[10:0]} (two's complement). Otherwise data_reg = sample_in unchanged.
- State CONVERT:
  - busy=1, ADC_SDO=0, counter decrements.
  - Any SCK edge or CONVST rise: pulse frame_err and ignore the event.
  - Counter reaches 0: go to READ with bit_cnt=0.
- State READ:
  - ADC_SDO = data_reg[11] when synced CONVST=0. ADC_SDO=0 while CONVST is high.
  - SCK rise (CONVST low): if bit_cnt < CFG_BITS, shift ADC_SDI into cfg_shift MSB-first. Then bit_cnt++, saturating at NBITS.
  - SCK fall (CONVST low): shift data_reg left, filling 0. After NBITS falls, ADC_SDO stays 0.
  - SCK edge while CONVST high: frame_err pulse; no shift.
  - Config commit: on the rise where bit_cnt reaches CFG_BITS, the committed config becomes cfg_shift and cfg_valid pulses. sample_ch/sample_diff update in the following cycle.
  - CONVST rise: end of frame; perform the IDLE CONVST-rise action immediately, using the committed config.
  - Frame with fewer than CFG_BITS rises: config is not updated and frame_err pulses. Mid-frame abort with at least CFG_BITS rises is legal and silent.
- Channel decode (S/D, O/S, S1, S0):
  - Single-ended: sample_ch = {S1, S0, O/S}, sample_diff=0.
  - Differential: sample_ch = {S1, S0, O/S}, sample_diff=1.
- Other config bits: SLP is stored but ignored. The config applies to the next conversion, not the current frame (pipeline of one, matching the real device).
- Reset mid-operation: asynchronous return to reset values; any partial frame is discarded.
- Simultaneous events: a CONVST rise in the same cycle as an SCK edge gives CONVST priority; the SCK edge is dropped without error.

Test Plan:
- After reset: sample_in=12'hABC, CONVST pulse, wait CONV_CYCLES, 12 SCK cycles with SDI=100010 → SDO bits 1010_1011_1100; cfg_valid pulses; sample_ch=0; first frame has no frame_err.
- Frame 1 SDI=110010 (CH1), frame 2 with sample_in=12'h123 → sample_ch=1 before frame-2 CONVST rise; SDO=0001_0010_0011.
- Commit UNI=0 (SDI=100000), then sample_in=12'h800 → next frame SDO=12'h000. sample_in=12'h7FF → SDO=12'hFFF.
- SCK toggled 3 times during CONVERT → 3 frame_err pulses, busy=1 for exactly CONV_CYCLES cycles, data unchanged.
- CONVST rise after only 4 SCK rises → frame_err, previous config retained, sample_take pulses, new conversion starts.
- reset_n low mid-READ after 5 bits → SDO=0 and sample_ch=0 immediately; a following full frame operates normally.
